// File: rtl/stage_if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one-at-a-time word fetches over a
// req/ack handshake and queues returned words for decode in a small FIFO.
module stage_if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;

  logic [31:0]     fifo_pc_q   [BUF_DEPTH];
  logic [31:0]     fifo_inst_q [BUF_DEPTH];

  logic            ack_ok;
  logic            pop;
  logic            push;
  logic [CW-1:0]   cnt_n;
  logic            room;
  logic [31:0]     pc_inc;
  logic [31:0]     tgt;

  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = addr_q;
  assign if_valid  = (cnt_q != '0);
  assign if_pc     = if_valid ? fifo_pc_q[rd_q]   : '0;
  assign if_inst   = if_valid ? fifo_inst_q[rd_q] : '0;

  // An ack is only meaningful while a request is actually on the bus.
  assign ack_ok = imem_ack & imem_req;
  assign pop    = if_valid & ~stall & ~redirect;
  assign push   = ack_ok & (state_q == S_WAIT) & ~redirect;
  assign cnt_n  = cnt_q + CW'(push) - CW'(pop);
  assign room   = (cnt_n < CW'(BUF_DEPTH));
  assign pc_inc = pc_q + 32'd4;
  assign tgt    = redirect_pc & ~32'd3;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    cnt_d   = cnt_n;
    rd_d    = pop  ? PW'(rd_q + 1'b1) : rd_q;
    wr_d    = push ? PW'(wr_q + 1'b1) : wr_q;

    if (redirect) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
      pc_d  = tgt;
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          addr_d  = tgt;
        end
        S_WAIT, S_DROP: begin
          // In-flight word belongs to the old path; reissue only once it has returned.
          if (ack_ok) begin
            state_d = S_WAIT;
            addr_d  = tgt;
          end else begin
            state_d = S_DROP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (room) begin
            state_d = S_WAIT;
            addr_d  = pc_q;
          end
        end
        S_WAIT: begin
          if (ack_ok) begin
            pc_d = pc_inc;
            if (room) begin
              addr_d = pc_inc;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (ack_ok) begin
            state_d = S_WAIT;
            addr_d  = pc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_q]   <= addr_q;
      fifo_inst_q[wr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_stage_if_fetch.sv
// Self-checking bench for stage_if_fetch: variable-latency memory model plus a
// scoreboard of the expected {pc, inst} stream seen by decode.
module tb_stage_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned mem_lat;
  int unsigned mem_wait;
  logic [31:0] exp_q[$];

  stage_if_fetch #(
    .RESET_PC (RESET_PC),
    .BUF_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_valid   (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] wfun(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill_q(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // One clock: retire what decode consumed, run the memory model, check the head.
  task automatic step();
    logic        cons;
    logic        pre_req;
    logic        pre_ack;
    logic        pre_redir;
    logic [31:0] pre_addr;
    logic [31:0] pre_tgt;
    cons      = if_valid & ~stall & ~redirect;
    pre_req   = imem_req;
    pre_ack   = imem_ack;
    pre_redir = redirect;
    pre_addr  = imem_addr;
    pre_tgt   = redirect_pc;
    @(posedge clk);
    #1;
    if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
    if (pre_redir) fill_q(pre_tgt & ~32'd3);
    if (pre_req && !pre_ack && imem_req) chk("addr_hold", imem_addr, pre_addr);
    if (pre_req && pre_ack) mem_wait = 0;
    imem_ack = 1'b0;
    if (imem_req) begin
      if (mem_wait >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = wfun(imem_addr);
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
    end
    if (if_valid) begin
      if (exp_q.size() > 0) begin
        chk("sb_pc", if_pc, exp_q[0]);
        chk("sb_inst", if_inst, wfun(exp_q[0]));
      end else begin
        chk("sb_underrun", 32'(if_valid), 32'd0);
      end
    end else begin
      chk("bubble_pc", if_pc, 32'd0);
      chk("bubble_inst", if_inst, 32'd0);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    rst      = 1'b0;
    mem_wait = 0;
    fill_q(RESET_PC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    n_cmp = 0;
    n_err = 0;

    // Zero-wait streaming, then a 6-cycle stall.
    mem_lat = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t1_addr", imem_addr, 32'(4 * k));
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_valid", 32'(if_valid), (k == 0) ? 32'd0 : 32'd1);
    end
    stall = 1'b1;
    repeat (6) step();
    chk("t2_req_drop", 32'(imem_req), 32'd0);
    chk("t2_valid", 32'(if_valid), 32'd1);
    stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t2_resume_valid", 32'(if_valid), 32'd1);
    end

    // Latency 3, redirect one cycle after the request to 0x8.
    mem_lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (imem_req && imem_addr == 32'h8) begin
        found = 1'b1;
        break;
      end
    end
    chk("t3_req8_seen", 32'(found), 32'd1);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    chk("t3_valid_flushed", 32'(if_valid), 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr != 32'h8) break;
      step();
    end
    chk("t3_new_addr", imem_addr, 32'h0000_0100);
    repeat (16) step();

    // Redirect coincident with an ack.
    mem_lat = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (imem_ack && imem_addr == 32'h4) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_ack_seen", 32'(found), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    chk("t4_valid", 32'(if_valid), 32'd0);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h0000_0200);
    repeat (12) step();

    // Asynchronous reset while a latency-4 request is outstanding.
    mem_lat = 4;
    do_reset();
    repeat (3) step();
    chk("t5_pre_req", 32'(imem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_req", 32'(imem_req), 32'd0);
    chk("t5_async_valid", 32'(if_valid), 32'd0);
    chk("t5_async_addr", imem_addr, 32'd0);
    chk("t5_async_pc", if_pc, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = ~wfun(RESET_PC);
    #1 rst = 1'b0;
    mem_wait = 0;
    fill_q(RESET_PC);
    step();
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_addr", imem_addr, RESET_PC);
    chk("t5_valid", 32'(if_valid), 32'd0);
    repeat (20) step();

    // Redirect to an unaligned address at the top of the address space.
    mem_lat = 0;
    do_reset();
    repeat (4) step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t6_addr_wrap", imem_addr, 32'h0000_0000);
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
